mac_stat_ctrl: RTL and testbench

MAC_STAT_CTRL -- requirements
Module: mac_stat_ctrl

---
 rtl/mac_stat_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mac_stat_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stat_ctrl.sv
// Per-port MAC RX/TX statistics counters with a byte-wide management port.
// Requests run IDLE -> SNAP -> RESP; a byte-0 read snapshots a counter so later bytes stay coherent.
module mac_stat_ctrl #(
  parameter int NPORT       = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int SAT_MODE    = 0,
  parameter int CLR_ON_READ = 1
) (
  input  logic                  clk,
  input  logic                  rstn_sys,
  input  logic [NPORT-1:0]      rx_mgnt_valid,
  input  logic [20*NPORT-1:0]   rx_mgnt_data,
  output logic [NPORT-1:0]      rx_mgnt_resp,
  input  logic [NPORT-1:0]      tx_mgnt_valid,
  input  logic [16*NPORT-1:0]   tx_mgnt_data,
  output logic [NPORT-1:0]      tx_mgnt_resp,
  input  logic                  sys_req_valid,
  input  logic                  sys_req_wr,
  input  logic [7:0]            sys_req_addr,
  output logic                  sys_resp_valid,
  output logic [7:0]            sys_resp_data,
  output logic [1:0]            dbg_state
);

  localparam int NCNT   = 6;
  localparam int NBYTES = CNT_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             req_addr_q, req_addr_d;
  logic                   req_wr_q, req_wr_d;
  logic [CNT_WIDTH-1:0]   shadow_q, shadow_d;
  logic [NPORT-1:0]       rx_resp_q, rx_resp_d, tx_resp_q, tx_resp_d;
  logic [NPORT-1:0]       rx_acc, tx_acc;
  logic                   resp_valid_q, resp_valid_d;
  logic [7:0]             resp_data_q, resp_data_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NPORT][NCNT];
  logic [CNT_WIDTH-1:0]   cnt_d [NPORT][NCNT];
  logic                   clr_all, clr_one;
  logic [CNT_WIDTH-1:0]   sel_cnt;
  logic [31:0]            shadow_ext;
  logic [2:0]             req_port, req_idx;
  logic [1:0]             req_byte;
  logic                   addr_ok;
  logic                   unused_bits;

  function automatic logic [CNT_WIDTH-1:0] add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SAT_MODE != 0 && s[CNT_WIDTH]) return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  assign req_port   = req_addr_q[7:5];
  assign req_idx    = req_addr_q[4:2];
  assign req_byte   = req_addr_q[1:0];
  assign addr_ok    = (int'(req_port) < NPORT) && (req_idx < 3'd6);
  assign shadow_ext = 32'(shadow_q);

  // An event is taken only while the channel's accept pulse is low.
  assign rx_acc    = rx_mgnt_valid & ~rx_resp_q;
  assign tx_acc    = tx_mgnt_valid & ~tx_resp_q;
  assign rx_resp_d = rx_acc;
  assign tx_resp_d = tx_acc;

  always_comb begin
    sel_cnt = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int c = 0; c < NCNT; c++) begin
        if (int'(req_port) == p && int'(req_idx) == c) sel_cnt = cnt_q[p][c];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_wr_d     = req_wr_q;
    shadow_d     = shadow_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    clr_all      = 1'b0;
    clr_one      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sys_req_valid) begin
          req_addr_d = sys_req_addr;
          req_wr_d   = sys_req_wr;
          state_d    = ST_SNAP;
        end
      end
      ST_SNAP: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = 8'h00;
        if (req_wr_q) begin
          if (req_addr_q == 8'hFF) clr_all = 1'b1;
          else if (addr_ok && req_byte == 2'd0) clr_one = 1'b1;
        end else if (addr_ok) begin
          if (req_byte == 2'd0) begin
            shadow_d    = sel_cnt;
            resp_data_d = sel_cnt[7:0];
            clr_one     = (CLR_ON_READ != 0);
          end else if (int'(req_byte) < NBYTES) begin
            resp_data_d = shadow_ext[{req_byte, 3'b000} +: 8];
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear and a same-cycle event combine: the cleared counter takes just the new increment.
  always_comb begin
    logic [CNT_WIDTH-1:0] base, inc;
    logic                 en;
    base        = '0;
    inc         = '0;
    en          = 1'b0;
    unused_bits = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      unused_bits = unused_bits ^ (^rx_mgnt_data[20*p+16 +: 4]) ^ (^tx_mgnt_data[16*p+13 +: 3]);
      for (int c = 0; c < NCNT; c++) begin
        base = (clr_all || (clr_one && int'(req_port) == p && int'(req_idx) == c))
               ? '0 : cnt_q[p][c];
        en   = 1'b0;
        inc  = '0;
        case (c)
          0: begin en = rx_acc[p] && (rx_mgnt_data[20*p+12 +: 4] == 4'h0); inc = 1; end
          1: begin
            en  = rx_acc[p] && (rx_mgnt_data[20*p+12 +: 4] == 4'h0);
            inc = CNT_WIDTH'(rx_mgnt_data[20*p +: 12]);
          end
          2: begin en = rx_acc[p] && (rx_mgnt_data[20*p+12 +: 4] != 4'h0); inc = 1; end
          3: begin en = tx_acc[p]; inc = 1; end
          4: begin en = tx_acc[p]; inc = CNT_WIDTH'(tx_mgnt_data[16*p +: 12]); end
          default: begin en = tx_acc[p] && tx_mgnt_data[16*p+12]; inc = 1; end
        endcase
        cnt_d[p][c] = en ? add_cnt(base, inc) : base;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      req_wr_q     <= 1'b0;
      shadow_q     <= '0;
      rx_resp_q    <= '0;
      tx_resp_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      for (int p = 0; p < NPORT; p++)
        for (int c = 0; c < NCNT; c++) cnt_q[p][c] <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_wr_q     <= req_wr_d;
      shadow_q     <= shadow_d;
      rx_resp_q    <= rx_resp_d;
      tx_resp_q    <= tx_resp_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      for (int p = 0; p < NPORT; p++)
        for (int c = 0; c < NCNT; c++) cnt_q[p][c] <= cnt_d[p][c];
    end
  end

  assign rx_mgnt_resp   = rx_resp_q;
  assign tx_mgnt_resp   = tx_resp_q;
  assign sys_resp_valid = resp_valid_q;
  assign sys_resp_data  = resp_data_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mac_stat_ctrl.sv
// Bench for mac_stat_ctrl: a 32-bit wrapping instance plus 16-bit saturating and wrapping
// instances share one stimulus stream; responses are checked against a queue of expected bytes.
module tb_mac_stat_ctrl;
  logic        clk = 1'b0;
  logic        rstn_sys = 1'b0;
  logic [3:0]  rx_mgnt_valid = '0;
  logic [79:0] rx_mgnt_data = '0;
  logic [3:0]  tx_mgnt_valid = '0;
  logic [63:0] tx_mgnt_data = '0;
  logic        sys_req_valid = 1'b0;
  logic        sys_req_wr = 1'b0;
  logic [7:0]  sys_req_addr = '0;

  logic [3:0] m_rx_resp, m_tx_resp, s_rx_resp, s_tx_resp, w_rx_resp, w_tx_resp;
  logic       m_resp_valid, s_resp_valid, w_resp_valid;
  logic [7:0] m_resp_data, s_resp_data, w_resp_data;
  logic [1:0] m_state, s_state, w_state;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int snap_cnt;
  logic [23:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  mac_stat_ctrl #(.NPORT(4), .CNT_WIDTH(32), .SAT_MODE(0), .CLR_ON_READ(1)) u_dut (
    .clk(clk), .rstn_sys(rstn_sys),
    .rx_mgnt_valid(rx_mgnt_valid), .rx_mgnt_data(rx_mgnt_data), .rx_mgnt_resp(m_rx_resp),
    .tx_mgnt_valid(tx_mgnt_valid), .tx_mgnt_data(tx_mgnt_data), .tx_mgnt_resp(m_tx_resp),
    .sys_req_valid(sys_req_valid), .sys_req_wr(sys_req_wr), .sys_req_addr(sys_req_addr),
    .sys_resp_valid(m_resp_valid), .sys_resp_data(m_resp_data), .dbg_state(m_state));

  mac_stat_ctrl #(.NPORT(4), .CNT_WIDTH(16), .SAT_MODE(1), .CLR_ON_READ(1)) u_sat (
    .clk(clk), .rstn_sys(rstn_sys),
    .rx_mgnt_valid(rx_mgnt_valid), .rx_mgnt_data(rx_mgnt_data), .rx_mgnt_resp(s_rx_resp),
    .tx_mgnt_valid(tx_mgnt_valid), .tx_mgnt_data(tx_mgnt_data), .tx_mgnt_resp(s_tx_resp),
    .sys_req_valid(sys_req_valid), .sys_req_wr(sys_req_wr), .sys_req_addr(sys_req_addr),
    .sys_resp_valid(s_resp_valid), .sys_resp_data(s_resp_data), .dbg_state(s_state));

  mac_stat_ctrl #(.NPORT(4), .CNT_WIDTH(16), .SAT_MODE(0), .CLR_ON_READ(1)) u_wrap (
    .clk(clk), .rstn_sys(rstn_sys),
    .rx_mgnt_valid(rx_mgnt_valid), .rx_mgnt_data(rx_mgnt_data), .rx_mgnt_resp(w_rx_resp),
    .tx_mgnt_valid(tx_mgnt_valid), .tx_mgnt_data(tx_mgnt_data), .tx_mgnt_resp(w_tx_resp),
    .sys_req_valid(sys_req_valid), .sys_req_wr(sys_req_wr), .sys_req_addr(sys_req_addr),
    .sys_resp_valid(w_resp_valid), .sys_resp_data(w_resp_data), .dbg_state(w_state));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response strobe pops one expected {main, sat16, wrap16} byte triple.
  always @(negedge clk) begin
    if (m_resp_valid || s_resp_valid || w_resp_valid) begin
      resp_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_resp observed=resp expected=none");
      end
      if (exp_q.size() > 0) begin
        logic [23:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_valid"}, {m_resp_valid, s_resp_valid, w_resp_valid}, 3'b111);
        check({t, "_m32"}, m_resp_data, e[23:16]);
        check({t, "_s16"}, s_resp_data, e[15:8]);
        check({t, "_w16"}, w_resp_data, e[7:0]);
      end
    end
  end

  task automatic rx_ev(input int p, input logic [19:0] d);
    rx_mgnt_valid[p] = 1'b1;
    rx_mgnt_data[20*p +: 20] = d;
    @(posedge clk); #1;
    rx_mgnt_valid[p] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tx_ev(input int p, input logic [15:0] d);
    tx_mgnt_valid[p] = 1'b1;
    tx_mgnt_data[16*p +: 16] = d;
    @(posedge clk); #1;
    tx_mgnt_valid[p] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic req(input string tag, input logic [7:0] addr, input logic wr,
                     input logic [7:0] em, input logic [7:0] es, input logic [7:0] ew);
    exp_q.push_back({em, es, ew});
    tag_q.push_back(tag);
    sys_req_valid = 1'b1;
    sys_req_addr  = addr;
    sys_req_wr    = wr;
    @(posedge clk); #1;
    sys_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] e);
    req(tag, addr, 1'b0, e, e, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_resp", m_rx_resp, 4'h0);
    check("rst_tx_resp", m_tx_resp, 4'h0);
    check("rst_resp_valid", m_resp_valid, 1'b0);
    check("rst_resp_data", m_resp_data, 8'h00);
    check("rst_state", m_state, 2'd0);
    rstn_sys = 1'b1;
    @(posedge clk); #1;
    rd("rst_cnt", 8'h00, 8'h00);

    // Port 1 RX: two good frames (64, 1518) and one with the CRC flag.
    rx_ev(1, 20'h00040);
    rx_ev(1, 20'h005EE);
    rx_ev(1, 20'h01040);
    rd("p1_good_b0", 8'h20, 8'h02);
    rd("p1_good_b1", 8'h21, 8'h00);
    rd("p1_good_b2", 8'h22, 8'h00);
    rd("p1_good_b3", 8'h23, 8'h00);
    rd("p1_bytes_b0", 8'h24, 8'h2E);
    rd("p1_bytes_b1", 8'h25, 8'h06);
    rd("p1_err", 8'h28, 8'h01);
    rd("p1_good_cleared", 8'h20, 8'h00);

    // Port 0 TX held valid for four cycles: accept pulses on alternate cycles.
    tx_mgnt_valid[0] = 1'b1;
    tx_mgnt_data[15:0] = 16'h1064;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("tx_resp_cyc%0d", i), m_tx_resp[0], (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    tx_mgnt_valid[0] = 1'b0;
    @(posedge clk); #1;
    rd("p0_tx_frames", 8'h0C, 8'h02);
    rd("p0_tx_bytes_b0", 8'h10, 8'hC8);
    rd("p0_tx_bytes_b1", 8'h11, 8'h00);
    rd("p0_tx_tte", 8'h14, 8'h02);

    // Single-counter write clear leaves neighbours alone; byte-1 write does nothing.
    tx_ev(0, 16'h0064);
    req("wr_b1_noop", 8'h0D, 1'b1, 8'h00, 8'h00, 8'h00);
    req("wr_clr_frames", 8'h0C, 1'b1, 8'h00, 8'h00, 8'h00);
    rd("p0_frames_after_clr", 8'h0C, 8'h00);
    rd("p0_bytes_kept", 8'h10, 8'h64);

    // Port 2: 16 x 4095 = 0xFFF0 then +64; saturates in 16-bit sat, wraps in 16-bit wrap.
    for (int i = 0; i < 16; i++) rx_ev(2, 20'h00FFF);
    rx_ev(2, 20'h00040);
    rd("p2_good", 8'h40, 8'h11);
    req("p2_bytes_b0", 8'h44, 1'b0, 8'h30, 8'hFF, 8'h30);
    rd("bad_port", 8'hE0, 8'h00);
    rd("bad_idx", 8'h18, 8'h00);
    req("p2_bytes_b1", 8'h45, 1'b0, 8'h00, 8'hFF, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("hold_data_s16", s_resp_data, 8'hFF);
    req("p2_bytes_b2", 8'h46, 1'b0, 8'h01, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("hold_data_m32", m_resp_data, 8'h01);

    // Port 3: rx_good=5, then an event lands in the SNAP cycle of a clearing read.
    for (int i = 0; i < 5; i++) rx_ev(3, 20'h00040);
    exp_q.push_back({8'h05, 8'h05, 8'h05});
    tag_q.push_back("p3_snap_race");
    sys_req_valid = 1'b1;
    sys_req_addr  = 8'h60;
    sys_req_wr    = 1'b0;
    @(posedge clk); #1;
    sys_req_valid = 1'b0;
    rx_mgnt_valid[3] = 1'b1;
    rx_mgnt_data[79:60] = 20'h00040;
    @(posedge clk); #1;
    rx_mgnt_valid[3] = 1'b0;
    @(posedge clk); #1;
    rd("p3_after_race", 8'h60, 8'h01);
    rd("p3_after_clr", 8'h60, 8'h00);

    // Global clear with the request held into SNAP: only one response.
    rx_ev(3, 20'h00040);
    snap_cnt = resp_cnt;
    exp_q.push_back(24'h000000);
    tag_q.push_back("wr_all");
    sys_req_valid = 1'b1;
    sys_req_addr  = 8'hFF;
    sys_req_wr    = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_req_valid = 1'b0;
    sys_req_wr    = 1'b0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    check("wr_all_one_resp", resp_cnt - snap_cnt, 1);
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 6; c++)
        rd($sformatf("cleared_p%0d_c%0d", p, c), 8'((p << 5) | (c << 2)), 8'h00);

    // Reset during SNAP aborts the request.
    tx_ev(1, 16'h0040);
    snap_cnt = resp_cnt;
    sys_req_valid = 1'b1;
    sys_req_addr  = 8'h2C;
    @(posedge clk); #1;
    sys_req_valid = 1'b0;
    check("snap_before_rst", m_state, 2'd1);
    rstn_sys = 1'b0;
    #1;
    check("rst_mid_state", m_state, 2'd0);
    @(posedge clk); #1;
    rstn_sys = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_resp", resp_cnt - snap_cnt, 0);
    rd("post_rst_tx_frames", 8'h2C, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
